// File: rtl/spi_peripheral_rf_if.sv
// SPI pin bundle between an SPI controller and the register-file peripheral.
// All signals are single-bit pad-level nets; cipo_oe drives the CIPO pad tristate.
interface spi_peripheral_rf_if;
  logic nCS;
  logic SCLK;
  logic COPI;
  logic CIPO;
  logic cipo_oe;

  modport master (output nCS, output SCLK, output COPI, input CIPO, input cipo_oe);
  modport slave  (input nCS, input SCLK, input COPI, output CIPO, output cipo_oe);
endinterface

// File: rtl/spi_peripheral_rf.sv
// Parametrised SPI mode-0 register file with read-back, write strobe and flat register bus.
// Optional saturating error counter output err_cnt when SPI_RF_ERR_CNT_EN is defined.
module spi_peripheral_rf #(
  parameter int unsigned NUM_REGS = 5,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  spi_peripheral_rf_if.slave         spi,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_stb,
  output logic [ADDR_W-1:0]          wr_addr
`ifdef SPI_RF_ERR_CNT_EN
  ,
  output logic [7:0]                 err_cnt
`endif
);

  localparam int unsigned FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int unsigned CMD_W   = 1 + ADDR_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);
  localparam int unsigned RX_W    = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
  localparam int unsigned REG_W   = NUM_REGS * DATA_W;
  localparam int unsigned AW1     = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, CMD, WR_DATA, RD_DATA} state_e;

  state_e            state_q, state_d;
  logic [1:0]        sclk_sync_q, ncs_sync_q, copi_sync_q;
  logic              sclk_prev_q, ncs_prev_q;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d, bit_cnt_inc;
  logic [RX_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0] tx_q, tx_d, rd_word;
  logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic [REG_W-1:0]  regs_q, regs_d;
  logic              wr_stb_q, wr_stb_d, cipo_q, cipo_d, oe_q, oe_d;
  logic              sclk_rise, sclk_fall, ncs_fall, ncs_rise, ncs_low, copi_s;
  logic              frame_full, addr_ok;
  logic [CMD_W-1:0]  cmd_word;

  assign sclk_rise   = sclk_sync_q[1] & ~sclk_prev_q;
  assign sclk_fall   = ~sclk_sync_q[1] & sclk_prev_q;
  assign ncs_fall    = ncs_prev_q & ~ncs_sync_q[1];
  assign ncs_rise    = ~ncs_prev_q & ncs_sync_q[1];
  assign ncs_low     = ~ncs_sync_q[1];
  assign copi_s      = copi_sync_q[1];
  assign frame_full  = (bit_cnt_q == CNT_W'(FRAME_W));
  assign addr_ok     = (AW1'(addr_q) < AW1'(NUM_REGS));
  assign cmd_word    = {rx_q[ADDR_W-1:0], copi_s};
  assign bit_cnt_inc = (bit_cnt_q == CNT_W'(FRAME_W + 1)) ? bit_cnt_q : bit_cnt_q + CNT_W'(1);

  // Read mux: out-of-range addresses return zero
  always_comb begin : rd_mux
    rd_word = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (cmd_word[ADDR_W-1:0] == ADDR_W'(i)) rd_word = regs_q[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin : fsm_comb
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    regs_d    = regs_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;

    if (state_q != IDLE && sclk_rise && ncs_low) begin
      rx_d      = RX_W'({rx_q, copi_s});
      bit_cnt_d = bit_cnt_inc;
    end

    case (state_q)
      IDLE: begin
        if (ncs_fall) begin
          state_d   = CMD;
          bit_cnt_d = '0;
          rx_d      = '0;
        end
      end
      CMD: begin
        if (sclk_rise && ncs_low && bit_cnt_q == CNT_W'(ADDR_W)) begin
          addr_d = cmd_word[ADDR_W-1:0];
          if (cmd_word[ADDR_W]) begin
            state_d = WR_DATA;
          end else begin
            state_d = RD_DATA;
            tx_d    = rd_word;
          end
        end
      end
      WR_DATA: begin
      end
      RD_DATA: begin
        // The fall right after the load must not shift: the MSB is not yet sampled
        if (sclk_fall && bit_cnt_q > CNT_W'(CMD_W)) tx_d = DATA_W'({tx_q, 1'b0});
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && ncs_rise) begin
      state_d = IDLE;
      if (state_q == WR_DATA && frame_full && addr_ok) begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
          if (addr_q == ADDR_W'(i)) regs_d[i*DATA_W +: DATA_W] = rx_q[DATA_W-1:0];
        end
        wr_stb_d  = 1'b1;
        wr_addr_d = addr_q;
      end
    end

    oe_d   = (state_d == RD_DATA) && ncs_low;
    cipo_d = oe_d && tx_d[DATA_W-1];
  end

  always_ff @(posedge clk) begin : seq
    if (rst) begin
      sclk_sync_q <= 2'b00;
      ncs_sync_q  <= 2'b11;
      copi_sync_q <= 2'b00;
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      addr_q      <= '0;
      regs_q      <= '0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      cipo_q      <= 1'b0;
      oe_q        <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], spi.SCLK};
      ncs_sync_q  <= {ncs_sync_q[0], spi.nCS};
      copi_sync_q <= {copi_sync_q[0], spi.COPI};
      sclk_prev_q <= sclk_sync_q[1];
      ncs_prev_q  <= ncs_sync_q[1];
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      regs_q      <= regs_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      cipo_q      <= cipo_d;
      oe_q        <= oe_d;
    end
  end

`ifdef SPI_RF_ERR_CNT_EN
  logic [7:0] err_q;
  logic       err_evt;

  // Aborted frames and writes to unimplemented addresses
  assign err_evt = (state_q != IDLE) && ncs_rise &&
                   (!frame_full || (state_q == WR_DATA && !addr_ok));

  always_ff @(posedge clk) begin : err_seq
    if (rst) begin
      err_q <= 8'd0;
    end else if (err_evt && err_q != 8'hFF) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_cnt = err_q;
`endif

  assign regs_flat   = regs_q;
  assign wr_stb      = wr_stb_q;
  assign wr_addr     = wr_addr_q;
  assign spi.CIPO    = cipo_q;
  assign spi.cipo_oe = oe_q;

endmodule

// File: tb/tb_spi_peripheral_rf.sv
// Directed bench for spi_peripheral_rf: default build (dev 0) plus a 16x16/ADDR_W=4 build (dev 1)
// sharing SCLK/COPI with separate chip selects; write strobes and read data go through scoreboards.
module tb_spi_peripheral_rf;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_peripheral_rf_if if0 ();
  spi_peripheral_rf_if if1 ();

  logic [39:0]  regs0;
  logic         stb0;
  logic [6:0]   waddr0;
  logic [255:0] regs1;
  logic         stb1;
  logic [3:0]   waddr1;
`ifdef SPI_RF_ERR_CNT_EN
  logic [7:0]   err0, err1;
  int           err_exp;
`endif

  spi_peripheral_rf u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .spi       (if0.slave),
    .regs_flat (regs0),
    .wr_stb    (stb0),
    .wr_addr   (waddr0)
`ifdef SPI_RF_ERR_CNT_EN
    ,
    .err_cnt   (err0)
`endif
  );

  spi_peripheral_rf #(.NUM_REGS(16), .DATA_W(16), .ADDR_W(4)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .spi       (if1.slave),
    .regs_flat (regs1),
    .wr_stb    (stb1),
    .wr_addr   (waddr1)
`ifdef SPI_RF_ERR_CNT_EN
    ,
    .err_cnt   (err1)
`endif
  );

  int tests  = 0;
  int failed = 0;
  int wr_q[$];            // expected commits: dev*1000 + addr
  logic [31:0] rd_q[$];   // expected read-back words
  logic [39:0]  exp_regs0;
  logic [255:0] exp_regs1;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write-strobe scoreboard consumer
  int mon_e;
  always @(negedge clk) begin
    if (!rst && stb0) begin
      if (wr_q.size() == 0) check("wr_stb0_unexpected", 256'(stb0), 256'(0));
      else begin
        mon_e = wr_q.pop_front();
        check("wr_addr0", 256'(waddr0), 256'(mon_e));
      end
    end
    if (!rst && stb1) begin
      if (wr_q.size() == 0) check("wr_stb1_unexpected", 256'(stb1), 256'(0));
      else begin
        mon_e = wr_q.pop_front();
        check("wr_addr1", 256'(1000 + int'(waddr1)), 256'(mon_e));
      end
    end
  end

  task automatic set_ncs(input int dev, input logic v);
    if (dev == 0) if0.nCS = v;
    else          if1.nCS = v;
  endtask

  task automatic set_bus(input logic s, input logic c);
    if0.SCLK = s; if1.SCLK = s;
    if0.COPI = c; if1.COPI = c;
  endtask

  // Shift nbits of val MSB first; CIPO/cipo_oe sampled just before each SCLK rise
  task automatic frame(input int dev, input int nbits, input logic [31:0] val, input bit release_cs,
                       output logic [31:0] cipo_bits, output logic [31:0] oe_bits);
    cipo_bits = '0;
    oe_bits   = '0;
    set_ncs(dev, 1'b0);
    repeat (4) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      set_bus(1'b0, val[i]);
      repeat (4) @(negedge clk);
      cipo_bits = {cipo_bits[30:0], (dev == 0) ? if0.CIPO : if1.CIPO};
      oe_bits   = {oe_bits[30:0], (dev == 0) ? if0.cipo_oe : if1.cipo_oe};
      set_bus(1'b1, val[i]);
      repeat (4) @(negedge clk);
    end
    set_bus(1'b0, 1'b0);
    if (release_cs) begin
      repeat (4) @(negedge clk);
      set_ncs(dev, 1'b1);
      repeat (8) @(negedge clk);
    end
  endtask

  logic [31:0] cb, ob, rexp;

  initial begin
    rst = 1'b1;
    if0.nCS = 1'b1; if1.nCS = 1'b1;
    set_bus(1'b0, 1'b0);
    exp_regs0 = '0;
    exp_regs1 = '0;
`ifdef SPI_RF_ERR_CNT_EN
    err_exp = 0;
`endif
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset_regs0", 256'(regs0), 256'(exp_regs0));
    check("reset_stb0", 256'(stb0), 256'(0));
    check("reset_waddr0", 256'(waddr0), 256'(0));
    check("reset_cipo0", 256'(if0.CIPO), 256'(0));
    check("reset_oe0", 256'(if0.cipo_oe), 256'(0));
    check("reset_regs1", regs1, exp_regs1);
`ifdef SPI_RF_ERR_CNT_EN
    check("reset_err0", 256'(err0), 256'(err_exp));
`endif

    // Write addr 0 = 0xA5
    wr_q.push_back(0);
    frame(0, 16, 32'h80A5, 1'b1, cb, ob);
    exp_regs0[7:0] = 8'hA5;
    check("wr0_regs", 256'(regs0), 256'(exp_regs0));
    check("wr0_stb_pending", 256'(wr_q.size()), 256'(0));

    // Write addr 4 = 0x3C, then read it back
    wr_q.push_back(4);
    frame(0, 16, {16'h0, 1'b1, 7'd4, 8'h3C}, 1'b1, cb, ob);
    exp_regs0[39:32] = 8'h3C;
    check("wr4_regs", 256'(regs0), 256'(exp_regs0));
    check("wr4_stb_pending", 256'(wr_q.size()), 256'(0));
    rd_q.push_back(32'h3C);
    frame(0, 16, {16'h0, 1'b0, 7'd4, 8'h00}, 1'b1, cb, ob);
    rexp = rd_q.pop_front();
    check("rd4_cipo", 256'(cb), 256'(rexp));
    check("rd4_oe", 256'(ob), 256'(32'h00FF));
    check("rd4_oe_after", 256'(if0.cipo_oe), 256'(0));
    check("rd4_regs", 256'(regs0), 256'(exp_regs0));
    check("rd4_waddr", 256'(waddr0), 256'(4));

    // Out-of-range address: write ignored, read returns zero
    frame(0, 16, {16'h0, 1'b1, 7'd6, 8'hFF}, 1'b1, cb, ob);
`ifdef SPI_RF_ERR_CNT_EN
    err_exp++;
    check("wr6_err", 256'(err0), 256'(err_exp));
`endif
    check("wr6_regs", 256'(regs0), 256'(exp_regs0));
    check("wr6_waddr", 256'(waddr0), 256'(4));
    rd_q.push_back(32'h00);
    frame(0, 16, {16'h0, 1'b0, 7'd6, 8'h00}, 1'b1, cb, ob);
    rexp = rd_q.pop_front();
    check("rd6_cipo", 256'(cb), 256'(rexp));
    check("rd6_oe", 256'(ob), 256'(32'h00FF));

    // Reset in the middle of a frame
    frame(0, 12, 32'h817, 1'b0, cb, ob);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    set_ncs(0, 1'b1);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_regs0 = '0;
`ifdef SPI_RF_ERR_CNT_EN
    err_exp = 0;
    check("rst_err", 256'(err0), 256'(err_exp));
`endif
    check("rst_regs", 256'(regs0), 256'(exp_regs0));
    check("rst_waddr", 256'(waddr0), 256'(0));
    wr_q.push_back(2);
    frame(0, 16, {16'h0, 1'b1, 7'd2, 8'h5A}, 1'b1, cb, ob);
    exp_regs0[23:16] = 8'h5A;
    check("wr2_regs", 256'(regs0), 256'(exp_regs0));
    check("wr2_stb_pending", 256'(wr_q.size()), 256'(0));

    // Short (10-bit) and long (17-bit) frames both abort
    frame(0, 10, 32'h205, 1'b1, cb, ob);
    check("short_regs", 256'(regs0), 256'(exp_regs0));
    frame(0, 17, 32'h102EF, 1'b1, cb, ob);
    check("long_regs", 256'(regs0), 256'(exp_regs0));
    check("long_waddr", 256'(waddr0), 256'(2));
`ifdef SPI_RF_ERR_CNT_EN
    err_exp += 2;
    check("abort_err", 256'(err0), 256'(err_exp));
`endif
    check("dev1_untouched", regs1, exp_regs1);

    // Wide build: write addr 15 = 0xBEEF and read it back
    wr_q.push_back(1000 + 15);
    frame(1, 21, {11'h0, 1'b1, 4'd15, 16'hBEEF}, 1'b1, cb, ob);
    exp_regs1[255:240] = 16'hBEEF;
    check("w15_regs1", regs1, exp_regs1);
    check("w15_stb_pending", 256'(wr_q.size()), 256'(0));
    rd_q.push_back(32'hBEEF);
    frame(1, 21, {11'h0, 1'b0, 4'd15, 16'h0000}, 1'b1, cb, ob);
    rexp = rd_q.pop_front();
    check("rd15_cipo", 256'(cb), 256'(rexp));
    check("rd15_oe", 256'(ob), 256'(32'hFFFF));
    rd_q.push_back(32'h0);
    frame(1, 21, {11'h0, 1'b0, 4'd3, 16'h0000}, 1'b1, cb, ob);
    rexp = rd_q.pop_front();
    check("rd3_cipo", 256'(cb), 256'(rexp));
    check("dev0_untouched", 256'(regs0), 256'(exp_regs0));

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/spi_peripheral_rf.md
Name: spi_peripheral_rf

Overview:
- Parametrised SPI (mode 0) register-file peripheral; successor to the fixed 5 x 8-bit write-only SPI block.
- Generalises register count, data width and address width.
- Adds read-back on CIPO, a per-write strobe and a full flattened register bus.
- Sits between the chip pins (nCS/SCLK/COPI/CIPO) and user logic that consumes configuration registers.

Parameters:
- NUM_REGS, 5, number of implemented registers (1..2^ADDR_W).
- DATA_W, 8, register width in bits (>=1).
- ADDR_W, 7, address field width in bits (>=1).
- Derived constant FRAME_W = 1 + ADDR_W + DATA_W (16 at defaults).

Ports:
- clk  input  1  system clock; all logic on posedge clk.
- rst  input  1  reset, synchronous, active-high.
- nCS  input  1  SPI chip select, active-low, asynchronous to clk.
- SCLK  input  1  SPI clock, asynchronous to clk.
- COPI  input  1  SPI controller-out data, asynchronous to clk.
- CIPO  output  1  SPI peripheral-out data.
- cipo_oe  output  1  high while CIPO is actively driven (pad tristate control).
- regs_flat  output  NUM_REGS*DATA_W  all registers; reg i at bits [i*DATA_W +: DATA_W].
- wr_stb  output  1  one-clk pulse when a register is committed.
- wr_addr  output  ADDR_W  address of last committed write.

Behaviour:
- Reset (rst high at posedge clk): sync regs SCLK=0, nCS=1, COPI=0; prev copies equal those values; all registers 0; state IDLE; bit_cnt 0; CIPO 0, cipo_oe 0, wr_stb 0, wr_addr 0. Applies mid-frame: any partial frame is discarded.
- Inputs pass through 2-FF synchronisers; edges are detected on the synced signals against a registered previous value.
- Requirement: f_clk >= 8 x f_SCLK.
- Frame format, MSB first: rw (1 = write, 0 = read), addr[ADDR_W-1:0], data[DATA_W-1:0]. COPI is sampled on synced SCLK rise while synced nCS is low.
- FSM states:
  - IDLE: on nCS fall -> CMD; clear bit_cnt and rx shift register.
  - CMD: shift COPI on each SCLK rise. When bit 1+ADDR_W is captured: if rw=1 -> WR_DATA. If rw=0 -> RD_DATA; in that same cycle load tx_shift with regs[addr], or all-zero if addr >= NUM_REGS.
  - WR_DATA: keep shifting on SCLK rise. On nCS rise with bit_cnt == FRAME_W: commit only if addr < NUM_REGS — write the register, pulse wr_stb for 1 clk, update wr_addr. Then -> IDLE.
  - RD_DATA: CIPO = tx_shift MSB; shift tx_shift left on each synced SCLK fall. Incoming COPI bits are counted but ignored. On nCS rise -> IDLE; registers unchanged.
- Any state: nCS rise with bit_cnt != FRAME_W aborts the frame (no write, no strobe) -> IDLE.
- bit_cnt saturates at FRAME_W+1. Any extra bits therefore invalidate the frame.
- cipo_oe = 1 only in RD_DATA while synced nCS is low. CIPO = 0 whenever cipo_oe = 0.
- Writes occur only on the nCS-rise cycle and loads only mid-frame, so a write and a read-load can never coincide.
- regs_flat updates the clk after the commit cycle, coincident with wr_stb.
- An address >= NUM_REGS is legal on the bus: writes are ignored and reads return 0.

Optional Feature:
- Macro SPI_RF_ERR_CNT_EN.
- Defined: adds output err_cnt [7:0], reset 0. It increments (saturating at 255) on every aborted frame and every write to an address >= NUM_REGS.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then write frame 0x8000|0x00A5 (rw=1, addr 0, data 0xA5) -> regs_flat[7:0]=0xA5; one wr_stb pulse; wr_addr=0.
- Write addr 4 data 0x3C, then read frame rw=0 addr 4 -> CIPO shifts out 0x3C MSB first in the data phase; cipo_oe high only during those 8 bits.
- Write addr 6 (>= NUM_REGS) data 0xFF -> no register change, no wr_stb; read addr 6 returns 0x00 (err_cnt=1 if SPI_RF_ERR_CNT_EN).
- nCS raised after 10 bits of a write to addr 1; then a 17-bit frame -> neither frame writes; regs unchanged; err_cnt=2 if enabled.
- rst asserted mid-frame after 12 bits, then a clean write addr 2 data 0x5A -> all regs 0 after reset; the following frame writes 0x5A correctly.
- Parameter run NUM_REGS=16, DATA_W=16, ADDR_W=4 (FRAME_W=21): write addr 15 data 0xBEEF, read it back -> regs_flat[255:240]=0xBEEF and CIPO returns 0xBEEF.
